// File: rtl/waveform_meas_fsm.sv
// Measures high and low phase lengths of an asynchronous single-bit waveform.
// Each closed period is reported with a one-cycle meas_valid strobe.
module waveform_meas_fsm #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] high_len,
    output logic [CNT_W-1:0] low_len,
    output logic [CNT_W:0]   period_len,
    output logic             meas_valid,
    output logic             meas_ovf,
    output logic             stuck
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_HIGH,
        S_LOW
    } state_t;

    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic             s1_q, sig_s_q, sig_d_q;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] lcnt_q, lcnt_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q, low_d;
    logic [CNT_W:0]   period_q, period_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             stuck_q, stuck_d;

    logic             rise, fall;
    logic [CNT_W-1:0] hinc, linc;

    assign rise = sig_s_q & ~sig_d_q;
    assign fall = ~sig_s_q & sig_d_q;

    // Saturating increments: a stuck line must never wrap into a short count.
    assign hinc = (hcnt_q == CMAX) ? hcnt_q : hcnt_q + ONE;
    assign linc = (lcnt_q == CMAX) ? lcnt_q : lcnt_q + ONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            s1_q     <= 1'b0;
            sig_s_q  <= 1'b0;
            sig_d_q  <= 1'b0;
            hcnt_q   <= '0;
            lcnt_q   <= '0;
            high_q   <= '0;
            low_q    <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= sig_in;
            sig_s_q  <= s1_q;
            sig_d_q  <= sig_s_q;
            hcnt_q   <= hcnt_d;
            lcnt_q   <= lcnt_d;
            high_q   <= high_d;
            low_q    <= low_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            stuck_q  <= stuck_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        hcnt_d   = hcnt_q;
        lcnt_d   = lcnt_q;
        high_d   = high_q;
        low_d    = low_q;
        period_d = period_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        if (!enable) begin
            state_d = S_IDLE;
            hcnt_d  = '0;
            lcnt_d  = '0;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_ARM;
                S_ARM: begin
                    if (rise) begin
                        hcnt_d  = ONE;
                        state_d = S_HIGH;
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        lcnt_d  = ONE;
                        state_d = S_LOW;
                    end else if (sig_s_q) begin
                        hcnt_d = hinc;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        high_d   = hcnt_q;
                        low_d    = lcnt_q;
                        period_d = {1'b0, hcnt_q} + {1'b0, lcnt_q};
                        ovf_d    = (hcnt_q == CMAX) | (lcnt_q == CMAX);
                        valid_d  = 1'b1;
                        hcnt_d   = ONE;
                        lcnt_d   = '0;
                        state_d  = S_HIGH;
                    end else if (!sig_s_q) begin
                        lcnt_d = linc;
                    end
                end
            endcase
        end
        stuck_d = ((state_d == S_HIGH) && (hcnt_d == CMAX)) ||
                  ((state_d == S_LOW) && (lcnt_d == CMAX));
    end

    assign high_len   = high_q;
    assign low_len    = low_q;
    assign period_len = period_q;
    assign meas_valid = valid_q;
    assign meas_ovf   = ovf_q;
    assign stuck      = stuck_q;

endmodule

// File: tb/tb_waveform_meas_fsm.sv
// Bench for waveform_meas_fsm: CNT_W=8 and CNT_W=4 instances share one input,
// a phase-length reference model feeds per-instance scoreboard queues.
module tb_waveform_meas_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, enable, sig_in;
    logic [7:0] h8, l8;
    logic [8:0] p8;
    logic v8, o8, st8;
    logic [3:0] h4, l4;
    logic [4:0] p4;
    logic v4, o4, st4;

    waveform_meas_fsm #(.CNT_W(8)) u8 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
        .high_len(h8), .low_len(l8), .period_len(p8),
        .meas_valid(v8), .meas_ovf(o8), .stuck(st8)
    );

    waveform_meas_fsm #(.CNT_W(4)) u4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
        .high_len(h4), .low_len(l4), .period_len(p4),
        .meas_valid(v4), .meas_ovf(o4), .stuck(st4)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int h;
        int l;
        int o;
    } meas_t;

    meas_t q0[$];
    meas_t q1[$];

    // Reference model: unbounded phase lengths, clipped only when reported.
    int mx[2] = '{255, 15};
    int mode[2];  // 0 off, 1 waiting for first rise, 2 in high, 3 in low
    int hl[2], ll[2];
    int eh[2], el[2], eo[2], ev[2], est[2];
    bit ms1, mss, msd;

    function automatic int sat(int v, int m);
        return (v > m) ? m : v;
    endfunction

    always @(posedge clk) begin
        bit rise, fall;
        meas_t m;
        rise = mss & ~msd;
        fall = ~mss & msd;
        for (int i = 0; i < 2; i++) begin
            ev[i] = 0;
            if (!rst_n) begin
                mode[i] = 0; hl[i] = 0; ll[i] = 0;
                eh[i] = 0; el[i] = 0; eo[i] = 0; est[i] = 0;
            end else if (!enable) begin
                mode[i] = 0; hl[i] = 0; ll[i] = 0; est[i] = 0;
            end else begin
                case (mode[i])
                    0: mode[i] = 1;
                    1: if (rise) begin mode[i] = 2; hl[i] = 1; end
                    2: if (fall) begin mode[i] = 3; ll[i] = 1; end
                       else if (mss) hl[i]++;
                    3: if (rise) begin
                           eh[i] = sat(hl[i], mx[i]);
                           el[i] = sat(ll[i], mx[i]);
                           eo[i] = (hl[i] >= mx[i]) || (ll[i] >= mx[i]);
                           ev[i] = 1;
                           m.h = eh[i]; m.l = el[i]; m.o = eo[i];
                           if (i == 0) q0.push_back(m);
                           else q1.push_back(m);
                           mode[i] = 2; hl[i] = 1; ll[i] = 0;
                       end else if (!mss) ll[i]++;
                    default: mode[i] = 0;
                endcase
                est[i] = ((mode[i] == 2) && (hl[i] >= mx[i])) ||
                         ((mode[i] == 3) && (ll[i] >= mx[i]));
            end
        end
        if (!rst_n) begin
            ms1 = 0; mss = 0; msd = 0;
        end else begin
            msd = mss; mss = ms1; ms1 = sig_in;
        end
    end

    // Monitor: per-cycle output/flag checks plus queue pop on every strobe.
    always @(negedge clk) begin
        meas_t m;
        chk("valid8", v8, ev[0]);
        chk("hold_h8", h8, eh[0]);
        chk("hold_l8", l8, el[0]);
        chk("hold_p8", p8, eh[0] + el[0]);
        chk("ovf8", o8, eo[0]);
        chk("stuck8", st8, est[0]);
        chk("valid4", v4, ev[1]);
        chk("hold_h4", h4, eh[1]);
        chk("hold_l4", l4, el[1]);
        chk("hold_p4", p4, eh[1] + el[1]);
        chk("ovf4", o4, eo[1]);
        chk("stuck4", st4, est[1]);
        if (v8 === 1'b1) begin
            if (q0.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL strobe8: got unexpected strobe expected none (t=%0t)", $time);
            end else begin
                m = q0.pop_front();
                chk("sb_h8", h8, m.h);
                chk("sb_l8", l8, m.l);
                chk("sb_p8", p8, m.h + m.l);
                chk("sb_o8", o8, m.o);
            end
        end
        if (v4 === 1'b1) begin
            if (q1.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL strobe4: got unexpected strobe expected none (t=%0t)", $time);
            end else begin
                m = q1.pop_front();
                chk("sb_h4", h4, m.h);
                chk("sb_l4", l4, m.l);
                chk("sb_p4", p4, m.h + m.l);
                chk("sb_o4", o4, m.o);
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(bit v, int n);
        sig_in = v;
        cyc(n);
    endtask

    task automatic wave(int h, int l, int n);
        repeat (n) begin
            drive(1'b1, h);
            drive(1'b0, l);
        end
    endtask

    task automatic out8(string tag, int h, int l, int o);
        chk({tag, "_h8"}, h8, h);
        chk({tag, "_l8"}, l8, l);
        chk({tag, "_p8"}, p8, h + l);
        chk({tag, "_o8"}, o8, o);
    endtask

    task automatic out4(string tag, int h, int l, int o);
        chk({tag, "_h4"}, h4, h);
        chk({tag, "_l4"}, l4, l);
        chk({tag, "_p4"}, p4, h + l);
        chk({tag, "_o4"}, o4, o);
    endtask

    initial begin
        int h, l;
        rst_n = 1'b0;
        enable = 1'b0;
        sig_in = 1'b0;
        @(negedge clk);
        cyc(2);
        out8("reset", 0, 0, 0);
        out4("reset", 0, 0, 0);
        rst_n = 1'b1;
        cyc(2);

        // 3 high / 5 low
        enable = 1'b1;
        wave(3, 5, 4);
        drive(1'b1, 4);
        out8("p35", 3, 5, 0);
        out4("p35", 3, 5, 0);

        // enable rises mid-high, then 4/6
        enable = 1'b0;
        drive(1'b0, 4);
        drive(1'b1, 2);
        enable = 1'b1;
        drive(1'b1, 2);
        drive(1'b0, 6);
        wave(4, 6, 3);
        drive(1'b1, 4);
        out8("p46", 4, 6, 0);

        // 20 high / 2 low: saturates the narrow instance
        drive(1'b1, 16);
        drive(1'b0, 2);
        drive(1'b1, 4);
        out4("sat", 15, 2, 1);
        out8("sat", 20, 2, 0);

        // enable dropped for one cycle mid-low
        drive(1'b0, 3);
        wave(3, 6, 2);
        drive(1'b1, 3);
        sig_in = 1'b0;
        cyc(3);
        enable = 1'b0;
        cyc(1);
        enable = 1'b1;
        cyc(3);
        out8("endrop", 3, 6, 0);
        wave(5, 4, 2);
        drive(1'b1, 4);
        out8("rearm", 5, 4, 0);

        // reset mid-high
        drive(1'b1, 2);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        out8("rst", 0, 0, 0);
        out4("rst", 0, 0, 0);
        drive(1'b1, 3);
        drive(1'b0, 5);
        wave(6, 3, 2);
        drive(1'b1, 4);
        out8("post_rst", 6, 3, 0);

        // 1 high / 1 low
        drive(1'b0, 2);
        wave(1, 1, 6);
        drive(1'b1, 4);
        out8("p11", 1, 1, 0);
        out4("p11", 1, 1, 0);

        // random periods with occasional one-cycle disable
        drive(1'b0, 3);
        repeat (60) begin
            h = $urandom_range(1, 20);
            l = $urandom_range(1, 20);
            drive(1'b1, h);
            if ($urandom_range(0, 7) == 0) begin
                enable = 1'b0;
                drive(1'b0, 1);
                enable = 1'b1;
            end
            drive(1'b0, l);
        end
        drive(1'b1, 5);
        drive(1'b0, 5);

        chk("q8_left", q0.size(), 0);
        chk("q4_left", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
